// File: rtl/sobel_stream_arbiter.sv
// Round-robin, frame-granular arbiter that shares one Sobel filter sink between two
// Avalon-ST pixel sources, enforcing a fixed frame length and counting completed frames.
module sobel_stream_arbiter #(
  parameter int DATA_W       = 8,
  parameter int FRAME_PIXELS = 76800,
  parameter int CNT_W        = 17
) (
  input  logic              csi_clkrst_clk,
  input  logic              csi_clkrst_reset_n,

  input  logic [DATA_W-1:0] asi_sink0_data,
  input  logic              asi_sink0_startofpacket,
  input  logic              asi_sink0_endofpacket,
  input  logic              asi_sink0_valid,
  output logic              asi_sink0_ready,

  input  logic [DATA_W-1:0] asi_sink1_data,
  input  logic              asi_sink1_startofpacket,
  input  logic              asi_sink1_endofpacket,
  input  logic              asi_sink1_valid,
  output logic              asi_sink1_ready,

  output logic [DATA_W-1:0] aso_source1_data,
  output logic              aso_source1_startofpacket,
  output logic              aso_source1_endofpacket,
  output logic              aso_source1_valid,
  input  logic              aso_source1_ready,

  output logic              coe_grant_o,
  output logic              coe_busy_o,
  output logic              coe_frame_err_o,
  output logic [15:0]       coe_frame_cnt0_o,
  output logic [15:0]       coe_frame_cnt1_o
);

  typedef enum logic [1:0] {IDLE, PASS, FLUSH} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS - 1);

  state_t             state;
  logic               g;
  logic               ptr;
  logic [CNT_W-1:0]   cnt;
  logic               err;
  logic [15:0]        frame_cnt0;
  logic [15:0]        frame_cnt1;

  logic [DATA_W-1:0]  sel_data;
  logic               sel_sop;
  logic               sel_eop;
  logic               sel_valid;
  logic               last_beat;
  logic               req0;
  logic               req1;
  logic               pass_xfer;

  assign sel_data  = g ? asi_sink1_data          : asi_sink0_data;
  assign sel_sop   = g ? asi_sink1_startofpacket : asi_sink0_startofpacket;
  assign sel_eop   = g ? asi_sink1_endofpacket   : asi_sink0_endofpacket;
  assign sel_valid = g ? asi_sink1_valid         : asi_sink0_valid;

  assign last_beat = (cnt == LAST_CNT);
  assign req0      = asi_sink0_valid & asi_sink0_startofpacket;
  assign req1      = asi_sink1_valid & asi_sink1_startofpacket;
  assign pass_xfer = sel_valid & aso_source1_ready;

  assign coe_grant_o      = g;
  assign coe_busy_o       = (state != IDLE);
  assign coe_frame_err_o  = err;
  assign coe_frame_cnt0_o = frame_cnt0;
  assign coe_frame_cnt1_o = frame_cnt1;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    aso_source1_data          = '0;
    aso_source1_startofpacket = 1'b0;
    aso_source1_endofpacket   = 1'b0;
    aso_source1_valid         = 1'b0;
    asi_sink0_ready           = 1'b0;
    asi_sink1_ready           = 1'b0;
    case (state)
      IDLE: begin
        // Stray mid-frame beats are swallowed; sop beats are held for the grant.
        asi_sink0_ready = asi_sink0_valid & ~asi_sink0_startofpacket;
        asi_sink1_ready = asi_sink1_valid & ~asi_sink1_startofpacket;
      end
      PASS: begin
        aso_source1_data          = sel_data;
        aso_source1_startofpacket = sel_sop;
        aso_source1_endofpacket   = sel_eop | last_beat;
        aso_source1_valid         = sel_valid;
        if (g) asi_sink1_ready = aso_source1_ready;
        else   asi_sink0_ready = aso_source1_ready;
      end
      FLUSH: begin
        if (g) asi_sink1_ready = 1'b1;
        else   asi_sink0_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge csi_clkrst_clk or negedge csi_clkrst_reset_n) begin
    if (!csi_clkrst_reset_n) begin
      state      <= IDLE;
      g          <= 1'b0;
      ptr        <= 1'b0;
      cnt        <= '0;
      err        <= 1'b0;
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req0 | req1) begin
            state <= PASS;
            g     <= (req0 & req1) ? ptr : req1;
          end
        end
        PASS: begin
          if (pass_xfer) begin
            cnt <= cnt + 1'b1;
            if (sel_eop || last_beat) begin
              // The filter saw a full (or short) frame either way, so it counts as completed.
              if (g) frame_cnt1 <= frame_cnt1 + 16'd1;
              else   frame_cnt0 <= frame_cnt0 + 16'd1;
              if (sel_eop) begin
                err   <= ~last_beat;
                ptr   <= ~g;
                state <= IDLE;
              end else begin
                err   <= 1'b1;
                state <= FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          if (sel_valid && sel_eop) begin
            ptr   <= ~g;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_stream_arbiter.sv
// Randomized bench for sobel_stream_arbiter with a frame-level reference model
// (expected beat stream, error pulses and per-channel frame counts).
module tb_sobel_stream_arbiter;

  localparam int DW = 8;
  localparam int FP = 16;

  typedef logic [7:0] frame_t [32];

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s0_data, s1_data, aso_data;
  logic          s0_sop, s0_eop, s0_valid, s0_ready;
  logic          s1_sop, s1_eop, s1_valid, s1_ready;
  logic          aso_sop, aso_eop, aso_valid;
  logic          aso_ready = 1'b1;
  logic          grant, busy, frame_err;
  logic [15:0]   cnt0, cnt1;

  int checks   = 0;
  int failures = 0;

  logic [9:0] act_q[$];
  logic [9:0] exp_q[$];
  int err_seen  = 0;
  int exp_err   = 0;
  int exp_cnt0  = 0;
  int exp_cnt1  = 0;
  bit mirror_en = 0;
  bit bp_en     = 0;

  sobel_stream_arbiter #(.DATA_W(DW), .FRAME_PIXELS(FP), .CNT_W(5)) dut (
    .csi_clkrst_clk            (clk),
    .csi_clkrst_reset_n        (rst_n),
    .asi_sink0_data            (s0_data),
    .asi_sink0_startofpacket   (s0_sop),
    .asi_sink0_endofpacket     (s0_eop),
    .asi_sink0_valid           (s0_valid),
    .asi_sink0_ready           (s0_ready),
    .asi_sink1_data            (s1_data),
    .asi_sink1_startofpacket   (s1_sop),
    .asi_sink1_endofpacket     (s1_eop),
    .asi_sink1_valid           (s1_valid),
    .asi_sink1_ready           (s1_ready),
    .aso_source1_data          (aso_data),
    .aso_source1_startofpacket (aso_sop),
    .aso_source1_endofpacket   (aso_eop),
    .aso_source1_valid         (aso_valid),
    .aso_source1_ready         (aso_ready),
    .coe_grant_o               (grant),
    .coe_busy_o                (busy),
    .coe_frame_err_o           (frame_err),
    .coe_frame_cnt0_o          (cnt0),
    .coe_frame_cnt1_o          (cnt1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    aso_ready = bp_en ? 1'($urandom_range(1)) : 1'b1;
  end

  // Output monitor: collects accepted beats, counts error-high cycles, checks ready mirroring.
  always @(negedge clk) begin
    if (aso_valid && aso_ready) act_q.push_back({aso_sop, aso_eop, aso_data});
    if (frame_err) err_seen++;
    if (mirror_en && busy && !grant) begin
      checks++;
      if (s0_ready !== aso_ready || s1_ready !== 1'b0) begin
        failures++;
        $display("FAIL ready_mirror t=%0t sink0_ready=%b sink1_ready=%b required %b/0",
                 $time, s0_ready, s1_ready, aso_ready);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic set_sink(input int s, input logic v, input logic [7:0] d,
                          input logic sop, input logic eop);
    if (s == 0) begin
      s0_valid = v; s0_data = d; s0_sop = sop; s0_eop = eop;
    end else begin
      s1_valid = v; s1_data = d; s1_sop = sop; s1_eop = eop;
    end
  endtask

  task automatic rand_frame(output frame_t f);
    for (int i = 0; i < 32; i++) f[i] = 8'($urandom);
  endtask

  // Reference model: the filter sees at most FP beats, eop on the last one it sees;
  // any length other than FP is an error; every frame counts as completed.
  task automatic expect_frame(input int s, input frame_t d, input int len);
    int n;
    n = (len < FP) ? len : FP;
    for (int i = 0; i < n; i++) exp_q.push_back({(i == 0), (i == n - 1), d[i]});
    if (len != FP) exp_err++;
    if (s == 0) exp_cnt0++; else exp_cnt1++;
  endtask

  // Called just after a rising edge; returns just after the edge of the last transfer.
  task automatic drive_frame(input int s, input frame_t d, input int len, input bit gaps);
    bit ok;
    int wait_cyc;
    for (int i = 0; i < len; i++) begin
      if (gaps && i > 0 && $urandom_range(3) == 0) begin
        set_sink(s, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
      end
      set_sink(s, 1'b1, d[i], (i == 0), (i == len - 1));
      wait_cyc = 0;
      do begin
        @(negedge clk);
        ok = (s == 0) ? s0_ready : s1_ready;
        @(posedge clk); #1;
        wait_cyc++;
      end while (!ok && wait_cyc < 300);
      if (!ok) begin
        checks++; failures++;
        $display("FAIL drive_timeout sink=%0d beat=%0d not accepted within 300 cycles", s, i);
        set_sink(s, 1'b0, 8'h00, 1'b0, 1'b0);
        return;
      end
    end
    set_sink(s, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bp_en = 0; mirror_en = 0;
    set_sink(0, 1'b0, 8'h00, 1'b0, 1'b0);
    set_sink(1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cnt0 = 0; exp_cnt1 = 0; exp_err = 0; err_seen = 0;
    act_q.delete(); exp_q.delete();
  endtask

  task automatic finish_test(input string name);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (act_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_beat_count got %0d beats, required %0d", name, act_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        if (act_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL %s_beat[%0d] got {sop,eop,data}=%h required %h", name, i, act_q[i], exp_q[i]);
          break;
        end
      end
    end
    checks++;
    if (err_seen != exp_err) begin
      failures++;
      $display("FAIL %s_err_pulses got %0d required %0d", name, err_seen, exp_err);
    end
    checks++;
    if (cnt0 !== 16'(exp_cnt0) || cnt1 !== 16'(exp_cnt1)) begin
      failures++;
      $display("FAIL %s_frame_cnt got %0d/%0d required %0d/%0d", name, cnt0, cnt1, exp_cnt0, exp_cnt1);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_busy_after got %b required 0", name, busy);
    end
    act_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_sink(0, 1'b1, 8'h5A, 1'b0, 1'b0);
    set_sink(1, 1'b0, 8'h00, 1'b0, 1'b0);
    #12;
    checks++;
    if ({aso_valid, aso_sop, aso_eop, aso_data, busy, frame_err, grant} !== '0 ||
        cnt0 !== 16'd0 || cnt1 !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs valid=%b sop=%b eop=%b data=%h busy=%b err=%b grant=%b cnt=%0d/%0d required all 0",
               aso_valid, aso_sop, aso_eop, aso_data, busy, frame_err, grant, cnt0, cnt1);
    end
    checks++;
    if (s0_ready !== 1'b1 || s1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard_ready got %b/%b required 1/0", s0_ready, s1_ready);
    end
    s0_sop = 1'b1;
    #1;
    checks++;
    if (s0_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_sop_hold got ready=%b required 0", s0_ready);
    end
    apply_reset();
  endtask

  task automatic test_single_frame();
    frame_t f;
    apply_reset();
    rand_frame(f);
    expect_frame(0, f, FP);
    fork
      drive_frame(0, f, FP, 1'b0);
      begin
        int n = 0;
        @(negedge clk);
        while (!s0_valid && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (aso_valid !== 1'b0 || s0_ready !== 1'b0) begin
          failures++;
          $display("FAIL grant_cycle got valid=%b ready=%b required 0/0", aso_valid, s0_ready);
        end
        @(negedge clk);
        checks++;
        if (aso_valid !== 1'b1 || aso_sop !== 1'b1 || aso_data !== f[0]) begin
          failures++;
          $display("FAIL first_beat_latency got valid=%b sop=%b data=%h required 1/1/%h",
                   aso_valid, aso_sop, aso_data, f[0]);
        end
      end
    join
    finish_test("single");
    checks++;
    if (grant !== 1'b0) begin
      failures++;
      $display("FAIL single_grant got %b required 0", grant);
    end
  endtask

  task automatic test_simultaneous();
    frame_t f0, f1;
    apply_reset();
    // After reset ptr=0; after sink1 finishes ptr=0 again: sink0 wins both rounds.
    for (int r = 0; r < 2; r++) begin
      rand_frame(f0); rand_frame(f1);
      expect_frame(0, f0, FP);
      expect_frame(1, f1, FP);
      fork
        drive_frame(0, f0, FP, 1'b1);
        drive_frame(1, f1, FP, 1'b1);
      join
    end
    // A lone sink0 frame leaves ptr=1, so the next tie goes to sink1.
    rand_frame(f0);
    expect_frame(0, f0, FP);
    drive_frame(0, f0, FP, 1'b0);
    rand_frame(f0); rand_frame(f1);
    expect_frame(1, f1, FP);
    expect_frame(0, f0, FP);
    fork
      drive_frame(0, f0, FP, 1'b0);
      drive_frame(1, f1, FP, 1'b0);
    join
    finish_test("simultaneous");
  endtask

  task automatic test_backpressure();
    frame_t f;
    apply_reset();
    bp_en = 1; mirror_en = 1;
    for (int k = 0; k < 4; k++) begin
      rand_frame(f);
      expect_frame(0, f, FP);
      drive_frame(0, f, FP, 1'b1);
    end
    mirror_en = 0;
    finish_test("backpressure");
    bp_en = 0;
  endtask

  task automatic test_long_frame();
    frame_t f;
    apply_reset();
    rand_frame(f);
    expect_frame(0, f, 20);
    drive_frame(0, f, 20, 1'b0);
    finish_test("long");
  endtask

  task automatic test_short_frame();
    frame_t f;
    apply_reset();
    rand_frame(f);
    expect_frame(1, f, 10);
    drive_frame(1, f, 10, 1'b0);
    rand_frame(f);
    expect_frame(1, f, FP);
    drive_frame(1, f, FP, 1'b1);
    finish_test("short");
    checks++;
    if (grant !== 1'b1) begin
      failures++;
      $display("FAIL short_grant got %b required 1", grant);
    end
  endtask

  task automatic test_stray();
    frame_t f;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      set_sink(i % 2, 1'b1, 8'($urandom), 1'b0, 1'($urandom_range(1)));
      @(negedge clk);
      checks++;
      if (((i % 2 == 0) ? s0_ready : s1_ready) !== 1'b1 || aso_valid !== 1'b0) begin
        failures++;
        $display("FAIL stray_beat[%0d] got ready0=%b ready1=%b valid=%b required ready=1 valid=0",
                 i, s0_ready, s1_ready, aso_valid);
      end
      @(posedge clk); #1;
      set_sink(i % 2, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    rand_frame(f);
    expect_frame(0, f, FP);
    drive_frame(0, f, FP, 1'b0);
    finish_test("stray");
  endtask

  task automatic test_reset_mid_pass();
    frame_t f;
    apply_reset();
    rand_frame(f);
    expect_frame(0, f, FP);
    drive_frame(0, f, FP, 1'b0);
    finish_test("pre_reset");
    set_sink(0, 1'b1, 8'h11, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_sink(0, 1'b1, 8'h22, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (aso_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_pass_active got valid=%b required 1", aso_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (aso_valid !== 1'b0 || aso_eop !== 1'b0 || busy !== 1'b0 || cnt0 !== 16'd0) begin
      failures++;
      $display("FAIL mid_pass_reset got valid=%b eop=%b busy=%b cnt0=%0d required 0/0/0/0",
               aso_valid, aso_eop, busy, cnt0);
    end
    set_sink(0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    exp_cnt0 = 0; exp_cnt1 = 0; exp_err = 0; err_seen = 0;
    act_q.delete(); exp_q.delete();
    rand_frame(f);
    expect_frame(0, f, FP);
    drive_frame(0, f, FP, 1'b0);
    finish_test("post_reset");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_simultaneous();
    test_backpressure();
    test_long_frame();
    test_short_frame();
    test_stray();
    test_reset_mid_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
